window_addr_gen: RTL and testbench
==================================

# window_addr_gen

Datapath companion to the median-filter controller. Owns the pixel row/column counters and the 9-address 3x3 neighbourhood generator with edge replication. Latches the fetched window for the median unit and registers the filtered result into the output image memory. It consumes the controller's Row_ctrl/Col_ctrl/data_ctrl/enable_wr codes and returns Col_done/Row_done.

## Interface
- IMG_W, default 8: image width in pixels, ≥ 2.
- IMG_H, default 8: image height in pixels, ≥ 2.
- PIX_W, default 8: pixel width in bits.
- ADDR_W, default 6: memory address width; 2^ADDR_W ≥ IMG_W*IMG_H.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- Col_ctrl  in  2  0 hold, 1 clear to 0, 2 increment, 3 hold.
- Row_ctrl  in  2  same encoding as Col_ctrl.
- data_ctrl  in  2  1 latch window, other values hold.
- enable_wr  in  2  1 write current pixel, other values no write.
- median_in  in  PIX_W  filtered pixel from the median unit.
- rd_data  in  9*PIX_W  input-memory read data, asynchronous read, slot k at [k*PIX_W +: PIX_W].
- rd_addr  out  9*ADDR_W  neighbourhood read addresses, slot k at [k*ADDR_W +: ADDR_W].
- window  out  9*PIX_W  latched 3x3 window, same slot order as rd_data.
- Col_done  out  1  col == IMG_W-1.
- Row_done  out  1  row == IMG_H-1.
- wr_en  out  1  output-memory write strobe.
- wr_addr  out  ADDR_W  output-memory write address.
- wr_data  out  PIX_W  output-memory write data.
- frame_done  out  1  one-cycle pulse with the last pixel's write.

## Operation
- **Counters**
  - row and col are registered.
  - Code 1 loads 0. Code 2 adds 1, and wraps to 0 past IMG_W-1 / IMG_H-1.
  - Codes 0 and 3 hold.
  - Row and col act independently; simultaneous Row_ctrl=2 and Col_ctrl=1 gives (row+1, 0).
- **Done flags:** Col_done and Row_done are combinational from the registered counters.
- **Neighbourhood addressing**
  - Slot k = 3*(dr+1)+(dc+1), with dr, dc ∈ {-1,0,1}. Slot 4 is the centre pixel.
  - r' = clamp(row+dr, 0, IMG_H-1); c' = clamp(col+dc, 0, IMG_W-1). This is edge replication.
  - rd_addr[k] = r'*IMG_W + c', combinational from the counters, truncated to ADDR_W.
- **Window latch:** when data_ctrl==1, window <= rd_data on the clock edge. Otherwise window holds.
- **Write path:** when enable_wr==1, the following are registered on the clock edge:
  - wr_en <= 1
  - wr_addr <= row*IMG_W+col
  - wr_data <= median_in
  - frame_done <= Col_done & Row_done
- **When enable_wr≠1:** wr_en and frame_done return to 0. wr_addr and wr_data hold.
- **Reset:** row, col, window, wr_en, wr_addr, wr_data and frame_done are all 0 immediately on rst assertion, including mid-frame.
  - After reset, Col_done = Row_done = 0.
  - rd_addr = the (0,0) neighbourhood: slots 0,1,3,4 = 0; slots 2,5 = 1; slots 6,7 = IMG_W; slot 8 = IMG_W+1.

## Timing
- Counter update: visible one cycle after the ctrl code is sampled. rd_addr and the done flags follow in the same cycle.
- rd_data must settle within the cycle data_ctrl==1 is presented. window is valid from the next cycle, for the controller's median-update state.
- Write latency: 1 cycle from enable_wr==1 to wr_en==1. The address captured is the pre-increment position, because the controller increments in the following state.
- Throughput: one pixel per 4 controller cycles (Load, Update, Write, Inc). This block imposes no stalls.
- frame_done is coincident with the final wr_en pulse. It never asserts without wr_en.

## Test plan
- **Reset values:** assert rst mid-frame at (3,5) → all registered outputs 0 at once; rd_addr slots = {0,0,1,0,0,1,8,8,9} for 8x8.
- **Column walk:** Col_ctrl=2 for 7 cycles from (0,0) → col=7, Col_done=1, rd_addr slot4=7, slot5=7 (clamped). One more increment → col=0, Col_done=0.
- **Row advance:** at (0,7), Row_ctrl=2 with Col_ctrl=1 → next cycle (1,0); rd_addr slot0=0, slot4=8, slot8=17.
- **Window latch:** rd_data slot k = 10k+1, data_ctrl=1 → next cycle window slot k = 10k+1. Change rd_data with data_ctrl=0 → window unchanged.
- **Write path:** at (2,3), median_in=0xA5, enable_wr=1 → next cycle wr_en=1, wr_addr=19, wr_data=0xA5, frame_done=0; following cycle wr_en=0.
- **Last pixel:** at (7,7), median_in=0x55, enable_wr=1 → Col_done=Row_done=1; next cycle wr_en=1, wr_addr=63, wr_data=0x55, frame_done=1 for exactly one cycle.

Source files
------------

// File: rtl/window_addr_gen.sv
// Pixel row/column counters, 3x3 edge-replicated neighbourhood address generator,
// window latch and output-image write register for the median-filter datapath.
module window_addr_gen #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            Col_ctrl,
    input  logic [1:0]            Row_ctrl,
    input  logic [1:0]            data_ctrl,
    input  logic [1:0]            enable_wr,
    input  logic [PIX_W-1:0]      median_in,
    input  logic [9*PIX_W-1:0]    rd_data,
    output logic [9*ADDR_W-1:0]   rd_addr,
    output logic [9*PIX_W-1:0]    window,
    output logic                  Col_done,
    output logic                  Row_done,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [PIX_W-1:0]      wr_data,
    output logic                  frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        row_q, row_d;
    logic [9*PIX_W-1:0]   window_q, window_d;
    logic                 wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]     wr_data_q, wr_data_d;
    logic                 frame_done_q, frame_done_d;

    assign Col_done = (col_q == CW'(IMG_W - 1));
    assign Row_done = (row_q == RW'(IMG_H - 1));

    always_comb begin
        col_d = col_q;
        case (Col_ctrl)
            2'd1:    col_d = '0;
            2'd2:    col_d = Col_done ? '0 : col_q + CW'(1);
            default: col_d = col_q;
        endcase
    end

    always_comb begin
        row_d = row_q;
        case (Row_ctrl)
            2'd1:    row_d = '0;
            2'd2:    row_d = Row_done ? '0 : row_q + RW'(1);
            default: row_d = row_q;
        endcase
    end

    // Neighbour coordinates are clamped to the image, replicating edge pixels.
    always_comb begin
        int r_n;
        int c_n;
        rd_addr = '0;
        r_n     = 0;
        c_n     = 0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                r_n = int'(row_q) + dr - 1;
                c_n = int'(col_q) + dc - 1;
                if (r_n < 0)      r_n = 0;
                if (r_n > IMG_H - 1) r_n = IMG_H - 1;
                if (c_n < 0)      c_n = 0;
                if (c_n > IMG_W - 1) c_n = IMG_W - 1;
                rd_addr[(3*dr + dc)*ADDR_W +: ADDR_W] = ADDR_W'(r_n*IMG_W + c_n);
            end
        end
    end

    always_comb begin
        window_d     = (data_ctrl == 2'd1) ? rd_data : window_q;
        wr_en_d      = (enable_wr == 2'd1);
        frame_done_d = (enable_wr == 2'd1) && Col_done && Row_done;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        if (enable_wr == 2'd1) begin
            // Captures the pre-increment position; the controller increments next state.
            wr_addr_d = ADDR_W'(int'(row_q)*IMG_W + int'(col_q));
            wr_data_d = median_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            window_q     <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            window_q     <= window_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign window     = window_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_addr_gen.sv
// Directed self-checking bench for window_addr_gen at the default 8x8 geometry.
module tb_window_addr_gen;

    localparam int IMG_W  = 8;
    localparam int IMG_H  = 8;
    localparam int PIX_W  = 8;
    localparam int ADDR_W = 6;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           Col_ctrl, Row_ctrl, data_ctrl, enable_wr;
    logic [PIX_W-1:0]     median_in;
    logic [9*PIX_W-1:0]   rd_data;
    logic [9*ADDR_W-1:0]  rd_addr;
    logic [9*PIX_W-1:0]   window;
    logic                 Col_done, Row_done, wr_en, frame_done;
    logic [ADDR_W-1:0]    wr_addr;
    logic [PIX_W-1:0]     wr_data;

    int n_checks = 0;
    int n_fail   = 0;

    window_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .Col_ctrl(Col_ctrl), .Row_ctrl(Row_ctrl), .data_ctrl(data_ctrl), .enable_wr(enable_wr),
        .median_in(median_in), .rd_data(rd_data), .rd_addr(rd_addr), .window(window),
        .Col_done(Col_done), .Row_done(Row_done), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Col_ctrl = 2'd0; Row_ctrl = 2'd0; data_ctrl = 2'd0; enable_wr = 2'd0;
    endtask

    task automatic test_reset();
        int exp_slot[9] = '{0, 0, 1, 0, 0, 1, 8, 8, 9};
        idle_inputs();
        Col_ctrl = 2'd1; Row_ctrl = 2'd1;
        tick();
        for (int i = 0; i < 5; i++) begin
            Col_ctrl = 2'd2;
            Row_ctrl = (i < 3) ? 2'd2 : 2'd0;
            tick();
        end
        idle_inputs();
        n_checks++;
        if (rd_addr[4*ADDR_W +: ADDR_W] !== 6'd29) begin
            $display("FAIL reset_setup_pos: got %0d expected 29", rd_addr[4*ADDR_W +: ADDR_W]);
            n_fail++;
        end
        enable_wr = 2'd1; data_ctrl = 2'd1; median_in = 8'h3C; rd_data = {9{8'hEE}};
        tick();
        n_checks++;
        if (wr_en !== 1'b1 || wr_addr !== 6'd29 || window !== {9{8'hEE}}) begin
            $display("FAIL reset_setup_wr: wr_en=%0b wr_addr=%0d expected 1/29", wr_en, wr_addr);
            n_fail++;
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0 || frame_done !== 1'b0 || window !== '0) begin
            $display("FAIL reset_regs: wr_en=%0b wr_addr=%0d wr_data=%0h fd=%0b window=%0h expected all 0",
                     wr_en, wr_addr, wr_data, frame_done, window);
            n_fail++;
        end
        n_checks++;
        if (Col_done !== 1'b0 || Row_done !== 1'b0) begin
            $display("FAIL reset_done: Col_done=%0b Row_done=%0b expected 0/0", Col_done, Row_done);
            n_fail++;
        end
        for (int k = 0; k < 9; k++) begin
            n_checks++;
            if (rd_addr[k*ADDR_W +: ADDR_W] !== ADDR_W'(exp_slot[k])) begin
                $display("FAIL reset_rd_addr[%0d]: got %0d expected %0d", k, rd_addr[k*ADDR_W +: ADDR_W], exp_slot[k]);
                n_fail++;
            end
        end
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_col_walk();
        idle_inputs();
        Col_ctrl = 2'd2;
        for (int i = 0; i < 7; i++) tick();
        idle_inputs();
        n_checks++;
        if (Col_done !== 1'b1 || Row_done !== 1'b0) begin
            $display("FAIL col_walk_done: Col_done=%0b Row_done=%0b expected 1/0", Col_done, Row_done);
            n_fail++;
        end
        n_checks++;
        if (rd_addr[4*ADDR_W +: ADDR_W] !== 6'd7 || rd_addr[5*ADDR_W +: ADDR_W] !== 6'd7 ||
            rd_addr[3*ADDR_W +: ADDR_W] !== 6'd6 || rd_addr[8*ADDR_W +: ADDR_W] !== 6'd15) begin
            $display("FAIL col_walk_addr: s3=%0d s4=%0d s5=%0d s8=%0d expected 6/7/7/15",
                     rd_addr[3*ADDR_W +: ADDR_W], rd_addr[4*ADDR_W +: ADDR_W],
                     rd_addr[5*ADDR_W +: ADDR_W], rd_addr[8*ADDR_W +: ADDR_W]);
            n_fail++;
        end
        Col_ctrl = 2'd2;
        tick();
        idle_inputs();
        n_checks++;
        if (Col_done !== 1'b0 || rd_addr[4*ADDR_W +: ADDR_W] !== 6'd0) begin
            $display("FAIL col_wrap: Col_done=%0b s4=%0d expected 0/0", Col_done, rd_addr[4*ADDR_W +: ADDR_W]);
            n_fail++;
        end
    endtask

    task automatic test_row_advance();
        idle_inputs();
        Col_ctrl = 2'd2;
        for (int i = 0; i < 7; i++) tick();
        Col_ctrl = 2'd1; Row_ctrl = 2'd2;
        tick();
        idle_inputs();
        n_checks++;
        if (rd_addr[0 +: ADDR_W] !== 6'd0 || rd_addr[4*ADDR_W +: ADDR_W] !== 6'd8 ||
            rd_addr[8*ADDR_W +: ADDR_W] !== 6'd17 || Col_done !== 1'b0) begin
            $display("FAIL row_advance: s0=%0d s4=%0d s8=%0d Col_done=%0b expected 0/8/17/0",
                     rd_addr[0 +: ADDR_W], rd_addr[4*ADDR_W +: ADDR_W], rd_addr[8*ADDR_W +: ADDR_W], Col_done);
            n_fail++;
        end
    endtask

    task automatic test_hold_codes();
        idle_inputs();
        Col_ctrl = 2'd3; Row_ctrl = 2'd0; enable_wr = 2'd2; data_ctrl = 2'd3;
        rd_data = {9{8'h77}}; median_in = 8'h99;
        tick();
        idle_inputs();
        n_checks++;
        if (rd_addr[4*ADDR_W +: ADDR_W] !== 6'd8 || wr_en !== 1'b0 || window === {9{8'h77}}) begin
            $display("FAIL hold_codes: s4=%0d wr_en=%0b window=%0h expected 8/0/not-latched",
                     rd_addr[4*ADDR_W +: ADDR_W], wr_en, window);
            n_fail++;
        end
    endtask

    task automatic test_window();
        logic [9*PIX_W-1:0] exp_win;
        for (int k = 0; k < 9; k++) exp_win[k*PIX_W +: PIX_W] = PIX_W'(10*k + 1);
        idle_inputs();
        rd_data = exp_win; data_ctrl = 2'd1;
        tick();
        idle_inputs();
        for (int k = 0; k < 9; k++) begin
            n_checks++;
            if (window[k*PIX_W +: PIX_W] !== PIX_W'(10*k + 1)) begin
                $display("FAIL window_latch[%0d]: got %0d expected %0d", k, window[k*PIX_W +: PIX_W], 10*k + 1);
                n_fail++;
            end
        end
        rd_data = {9{8'hC3}};
        tick();
        n_checks++;
        if (window !== exp_win) begin
            $display("FAIL window_hold: got %0h expected %0h", window, exp_win);
            n_fail++;
        end
    endtask

    task automatic test_write();
        idle_inputs();
        Col_ctrl = 2'd1; Row_ctrl = 2'd1;
        tick();
        for (int i = 0; i < 3; i++) begin
            Col_ctrl = 2'd2;
            Row_ctrl = (i < 2) ? 2'd2 : 2'd0;
            tick();
        end
        idle_inputs();
        median_in = 8'hA5; enable_wr = 2'd1;
        tick();
        enable_wr = 2'd0;
        n_checks++;
        if (wr_en !== 1'b1 || wr_addr !== 6'd19 || wr_data !== 8'hA5 || frame_done !== 1'b0) begin
            $display("FAIL write_path: wr_en=%0b wr_addr=%0d wr_data=%0h fd=%0b expected 1/19/a5/0",
                     wr_en, wr_addr, wr_data, frame_done);
            n_fail++;
        end
        median_in = 8'h11;
        tick();
        n_checks++;
        if (wr_en !== 1'b0 || wr_addr !== 6'd19 || wr_data !== 8'hA5) begin
            $display("FAIL write_release: wr_en=%0b wr_addr=%0d wr_data=%0h expected 0/19/a5",
                     wr_en, wr_addr, wr_data);
            n_fail++;
        end
    endtask

    task automatic test_last_pixel();
        idle_inputs();
        Col_ctrl = 2'd1; Row_ctrl = 2'd1;
        tick();
        Col_ctrl = 2'd2; Row_ctrl = 2'd2;
        for (int i = 0; i < 7; i++) tick();
        idle_inputs();
        n_checks++;
        if (Col_done !== 1'b1 || Row_done !== 1'b1 || rd_addr[8*ADDR_W +: ADDR_W] !== 6'd63 ||
            rd_addr[0 +: ADDR_W] !== 6'd54) begin
            $display("FAIL last_pos: Col_done=%0b Row_done=%0b s0=%0d s8=%0d expected 1/1/54/63",
                     Col_done, Row_done, rd_addr[0 +: ADDR_W], rd_addr[8*ADDR_W +: ADDR_W]);
            n_fail++;
        end
        median_in = 8'h55; enable_wr = 2'd1;
        Col_ctrl = 2'd0;
        tick();
        enable_wr = 2'd0;
        n_checks++;
        if (wr_en !== 1'b1 || wr_addr !== 6'd63 || wr_data !== 8'h55 || frame_done !== 1'b1) begin
            $display("FAIL last_write: wr_en=%0b wr_addr=%0d wr_data=%0h fd=%0b expected 1/63/55/1",
                     wr_en, wr_addr, wr_data, frame_done);
            n_fail++;
        end
        Col_ctrl = 2'd2; Row_ctrl = 2'd2;
        tick();
        idle_inputs();
        n_checks++;
        if (frame_done !== 1'b0 || wr_en !== 1'b0) begin
            $display("FAIL last_pulse_width: fd=%0b wr_en=%0b expected 0/0", frame_done, wr_en);
            n_fail++;
        end
        n_checks++;
        if (Row_done !== 1'b0 || Col_done !== 1'b0 || rd_addr[4*ADDR_W +: ADDR_W] !== 6'd0) begin
            $display("FAIL frame_wrap: Row_done=%0b Col_done=%0b s4=%0d expected 0/0/0",
                     Row_done, Col_done, rd_addr[4*ADDR_W +: ADDR_W]);
            n_fail++;
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        median_in = '0;
        rd_data = '0;
        #12 rst = 1'b0;
        test_reset();
        test_col_walk();
        test_row_advance();
        test_hold_codes();
        test_window();
        test_write();
        test_last_pixel();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
